// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller with masked priority select
// and a three-state ack/eoi handshake to the host.
module irq_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] int_req,
  input  logic [DATA_WIDTH-1:0] int_mask,
  input  logic                  irq_ack,
  input  logic                  irq_eoi,
  output logic                  irq_out,
  output logic [ID_WIDTH-1:0]   irq_id,
  output logic                  in_service,
  output logic [DATA_WIDTH-1:0] pending
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ASSERT  = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] prev_req;
  logic [DATA_WIDTH-1:0] req_edge;
  logic [DATA_WIDTH-1:0] eligible;
  logic [DATA_WIDTH-1:0] clr_vec;
  logic [ID_WIDTH-1:0]   sel_id;
  logic                  take_ack;

  assign req_edge = int_req & ~prev_req;
  assign eligible = pending & ~int_mask;
  assign take_ack = (state == ASSERT) && irq_ack;

  // Ascending scan so the highest eligible index wins
  always_comb begin
    sel_id = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (eligible[i]) sel_id = ID_WIDTH'(i);
    end
  end

  always_comb begin
    clr_vec = '0;
    if (take_ack) clr_vec[irq_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev_req   <= '0;
      pending    <= '0;
      irq_out    <= 1'b0;
      irq_id     <= '0;
      in_service <= 1'b0;
    end else begin
      prev_req <= int_req;
      // A fresh edge beats the ack clear on the same line
      pending  <= (pending & ~clr_vec) | req_edge;
      unique case (state)
        IDLE: begin
          if (|eligible) begin
            state   <= ASSERT;
            irq_id  <= sel_id;
            irq_out <= 1'b1;
          end
        end
        ASSERT: begin
          if (irq_ack) begin
            state      <= SERVICE;
            irq_out    <= 1'b0;
            in_service <= 1'b1;
          end
        end
        SERVICE: begin
          if (irq_eoi) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          irq_out    <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl with immediate-assertion checks.
module tb_irq_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] int_req;
  logic [3:0] int_mask;
  logic       irq_ack;
  logic       irq_eoi;
  logic       irq_out;
  logic [1:0] irq_id;
  logic       in_service;
  logic [3:0] pending;

  int checks;
  int errors;

  irq_ctrl #(.DATA_WIDTH(4), .ID_WIDTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .int_req    (int_req),
    .int_mask   (int_mask),
    .irq_ack    (irq_ack),
    .irq_eoi    (irq_eoi),
    .irq_out    (irq_out),
    .irq_id     (irq_id),
    .in_service (in_service),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int o, input int id,
                         input int s, input int p);
    chk({tag, ".irq_out"}, int'(irq_out), o);
    chk({tag, ".irq_id"}, int'(irq_id), id);
    chk({tag, ".in_service"}, int'(in_service), s);
    chk({tag, ".pending"}, int'(pending), p);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    int_req  = 4'h0;
    int_mask = 4'h0;
    irq_ack  = 1'b0;
    irq_eoi  = 1'b0;
    tick();
    tick();
    chk_out("reset", 0, 0, 0, 4'h0);
    rst = 1'b0;

    // ack and eoi while idle are ignored
    irq_ack = 1'b1;
    irq_eoi = 1'b1;
    tick();
    chk_out("idle_ack", 0, 0, 0, 4'h0);
    irq_ack = 1'b0;
    irq_eoi = 1'b0;

    // single request on line 2
    int_req = 4'b0100;
    tick();
    chk_out("single_e1", 0, 0, 0, 4'b0100);
    tick();
    chk_out("single_e2", 1, 2, 0, 4'b0100);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk_out("single_ack", 0, 2, 1, 4'b0000);
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    chk_out("single_eoi", 0, 2, 0, 4'b0000);
    int_req = 4'b0000;
    tick();

    // priority: 3, then 1, then 0
    int_req = 4'b1011;
    tick();
    chk_out("prio_set", 0, 2, 0, 4'b1011);
    tick();
    chk_out("prio_3", 1, 3, 0, 4'b1011);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk_out("prio_3ack", 0, 3, 1, 4'b0011);
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    tick();
    chk_out("prio_1", 1, 1, 0, 4'b0011);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    tick();
    chk_out("prio_0", 1, 0, 0, 4'b0001);
    // ack+eoi together in ASSERT behave as ack only
    irq_ack = 1'b1;
    irq_eoi = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_eoi = 1'b0;
    chk_out("ack_eoi", 0, 0, 1, 4'b0000);
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    chk_out("prio_done", 0, 0, 0, 4'b0000);
    int_req = 4'b0000;
    tick();

    // masked line waits until unmasked
    int_mask = 4'b1000;
    int_req  = 4'b1000;
    tick();
    tick();
    tick();
    chk_out("mask_hold", 0, 0, 0, 4'b1000);
    int_mask = 4'b0000;
    tick();
    chk_out("mask_clear", 1, 3, 0, 4'b1000);
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    chk_out("assert_eoi", 1, 3, 0, 4'b1000);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    chk_out("mask_done", 0, 3, 0, 4'b0000);
    int_req = 4'b0000;
    tick();

    // hold-stable while higher line arrives
    int_req = 4'b0001;
    tick();
    tick();
    chk_out("hold_0", 1, 0, 0, 4'b0001);
    int_req = 4'b1001;
    tick();
    chk_out("hold_hi", 1, 0, 0, 4'b1001);
    tick();
    chk_out("hold_hi2", 1, 0, 0, 4'b1001);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk_out("hold_ack", 0, 0, 1, 4'b1000);
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    tick();
    chk_out("hold_3", 1, 3, 0, 4'b1000);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    int_req = 4'b0000;
    tick();

    // re-edge on the served line in the ack cycle
    int_req = 4'b0100;
    tick();
    tick();
    chk_out("setw_assert", 1, 2, 0, 4'b0100);
    int_req = 4'b0000;
    tick();
    int_req = 4'b0100;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk_out("setw_ack", 0, 2, 1, 4'b0100);
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    tick();
    chk_out("setw_again", 1, 2, 0, 4'b0100);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_eoi = 1'b1;
    tick();
    irq_eoi = 1'b0;
    int_req = 4'b0000;
    tick();

    // reset mid-SERVICE with line 1 held high
    int_req = 4'b0010;
    tick();
    tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk_out("rst_svc", 0, 1, 1, 4'b0000);
    rst = 1'b1;
    tick();
    chk_out("rst_mid", 0, 0, 0, 4'b0000);
    rst = 1'b0;
    tick();
    chk_out("rst_edge", 0, 0, 0, 4'b0010);
    tick();
    chk_out("rst_present", 1, 1, 0, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
